// File: rtl/pdes_dispatch_ctrl.sv
// Dispatch controller for a PDES accelerator core: owns the AEG register file,
// sequences the core through IDLE/RUN/DONE/ABORT and serves CSR status reads.
module pdes_dispatch_ctrl #(
  parameter int unsigned NUM_AEG   = 8,
  parameter int unsigned AEG_IDX_W = 3,
  parameter int unsigned GVT_W     = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   disp_inst_vld,
  input  logic [4:0]             disp_inst,
  input  logic [17:0]            disp_aeg_idx,
  input  logic                   disp_aeg_rd,
  input  logic                   disp_aeg_wr,
  input  logic [63:0]            disp_aeg_wr_data,
  output logic [17:0]            disp_aeg_cnt,
  output logic [15:0]            disp_exception,
  output logic                   disp_idle,
  output logic                   disp_stall,
  output logic                   disp_rtn_data_vld,
  output logic [63:0]            disp_rtn_data,
  input  logic                   is_master,
  input  logic                   core_done,
  input  logic [GVT_W-1:0]       core_gvt,
  output logic                   core_rst_n,
  output logic [NUM_AEG*64-1:0]  aeg_flat,
  input  logic                   csr_rd_vld,
  input  logic [15:0]            csr_address,
  output logic                   csr_rd_ack,
  output logic [63:0]            csr_rd_data
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DONE  = 2'd2,
    ST_ABORT = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    END_NONE    = 2'd0,
    END_DONE    = 2'd1,
    END_TIMEOUT = 2'd2,
    END_ABORT   = 2'd3
  } end_t;

  state_t      state, state_nx;
  end_t        last_end, last_end_nx;
  logic [63:0] aeg [NUM_AEG];

  logic inst_start, inst_abort, inst_bad;
  logic idx_ok, bad_idx;
  logic run_done, timeout_hit, timeout_fire;

  assign inst_start  = disp_inst_vld && (disp_inst == 5'd0);
  assign inst_abort  = disp_inst_vld && (disp_inst == 5'd1);
  assign inst_bad    = disp_inst_vld && (disp_inst > 5'd1);
  assign idx_ok      = disp_aeg_idx < 18'(NUM_AEG);
  assign bad_idx     = (disp_aeg_rd || disp_aeg_wr) && !idx_ok;

  // Non-masters finish immediately; a master finishes on core_done.
  assign run_done     = (state == ST_RUN) && (!is_master || core_done);
  assign timeout_hit  = (state == ST_RUN) && (aeg[6] != '0) && (aeg[5] == aeg[6] - 64'd1);
  assign timeout_fire = timeout_hit && !run_done;

  assign disp_aeg_cnt = 18'(NUM_AEG);
  // A start is only pending while inst 0 is presented in IDLE; it is taken at the next edge.
  assign disp_idle    = (state == ST_IDLE) && !inst_start;
  assign disp_stall   = (state != ST_IDLE) || inst_start;

  for (genvar g = 0; g < NUM_AEG; g++) begin : g_flat
    assign aeg_flat[g*64 +: 64] = aeg[g];
  end

  // Next-state and end-reason selection; done beats timeout beats abort.
  always_comb begin
    state_nx    = state;
    last_end_nx = last_end;
    unique case (state)
      ST_IDLE: if (inst_start) state_nx = ST_RUN;
      ST_RUN: begin
        if (run_done) begin
          state_nx    = ST_DONE;
          last_end_nx = END_DONE;
        end else if (timeout_hit) begin
          state_nx    = ST_ABORT;
          last_end_nx = END_TIMEOUT;
        end else if (inst_abort) begin
          state_nx    = ST_ABORT;
          last_end_nx = END_ABORT;
        end
      end
      ST_DONE, ST_ABORT: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // FSM, AEG file, registered dispatch/core/CSR outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= ST_IDLE;
      last_end          <= END_NONE;
      core_rst_n        <= 1'b0;
      disp_exception    <= '0;
      disp_rtn_data_vld <= 1'b0;
      disp_rtn_data     <= '0;
      csr_rd_ack        <= 1'b0;
      csr_rd_data       <= '0;
      for (int unsigned i = 0; i < NUM_AEG; i++) aeg[i] <= '0;
    end else begin
      state          <= state_nx;
      last_end       <= last_end_nx;
      core_rst_n     <= (state_nx == ST_RUN) && is_master;
      disp_exception <= {13'h0, timeout_fire, bad_idx, inst_bad};

      for (int unsigned i = 0; i < NUM_AEG; i++) begin
        if (disp_aeg_wr && (disp_aeg_idx == 18'(i)) && i != 4 && i != 5 && i != 7)
          aeg[i] <= disp_aeg_wr_data;
      end

      if ((state == ST_IDLE) && inst_start)
        aeg[5] <= '0;
      else if ((state == ST_RUN) && (aeg[5] != '1))
        aeg[5] <= aeg[5] + 64'd1;

      if ((state == ST_RUN) && is_master && core_done)
        aeg[4] <= 64'(core_gvt);

      // Status snapshot pairs the end reason being recorded with the state it was
      // recorded from, so it trails the live FSM state by one cycle.
      aeg[7] <= {60'h0, last_end_nx, state};

      disp_rtn_data_vld <= disp_aeg_rd;
      disp_rtn_data     <= (disp_aeg_rd && idx_ok) ? aeg[disp_aeg_idx[AEG_IDX_W-1:0]] : '0;

      csr_rd_ack <= csr_rd_vld;
      if (csr_rd_vld) begin
        unique case (csr_address)
          16'd0:   csr_rd_data <= aeg[7];
          16'd1:   csr_rd_data <= aeg[4];
          16'd2:   csr_rd_data <= aeg[5];
          default: csr_rd_data <= '0;
        endcase
      end else begin
        csr_rd_data <= '0;
      end
    end
  end

endmodule

// File: tb/tb_pdes_dispatch_ctrl.sv
// Bench for pdes_dispatch_ctrl: scoreboarded AEG/CSR reads plus direct checks
// of FSM-visible outputs across master, timeout, abort, non-master and reset runs.
module tb_pdes_dispatch_ctrl;

  localparam int unsigned NUM_AEG = 8;
  localparam int unsigned GVT_W   = 16;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  disp_inst_vld;
  logic [4:0]            disp_inst;
  logic [17:0]           disp_aeg_idx;
  logic                  disp_aeg_rd;
  logic                  disp_aeg_wr;
  logic [63:0]           disp_aeg_wr_data;
  logic [17:0]           disp_aeg_cnt;
  logic [15:0]           disp_exception;
  logic                  disp_idle;
  logic                  disp_stall;
  logic                  disp_rtn_data_vld;
  logic [63:0]           disp_rtn_data;
  logic                  is_master;
  logic                  core_done;
  logic [GVT_W-1:0]      core_gvt;
  logic                  core_rst_n;
  logic [NUM_AEG*64-1:0] aeg_flat;
  logic                  csr_rd_vld;
  logic [15:0]           csr_address;
  logic                  csr_rd_ack;
  logic [63:0]           csr_rd_data;

  int unsigned total = 0;
  int unsigned bad   = 0;

  logic [63:0] rtn_q [$];
  logic [63:0] csr_q [$];
  logic [63:0] shadow [NUM_AEG];

  pdes_dispatch_ctrl #(.NUM_AEG(NUM_AEG), .AEG_IDX_W(3), .GVT_W(GVT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .disp_inst_vld(disp_inst_vld), .disp_inst(disp_inst),
    .disp_aeg_idx(disp_aeg_idx), .disp_aeg_rd(disp_aeg_rd),
    .disp_aeg_wr(disp_aeg_wr), .disp_aeg_wr_data(disp_aeg_wr_data),
    .disp_aeg_cnt(disp_aeg_cnt), .disp_exception(disp_exception),
    .disp_idle(disp_idle), .disp_stall(disp_stall),
    .disp_rtn_data_vld(disp_rtn_data_vld), .disp_rtn_data(disp_rtn_data),
    .is_master(is_master), .core_done(core_done), .core_gvt(core_gvt),
    .core_rst_n(core_rst_n), .aeg_flat(aeg_flat),
    .csr_rd_vld(csr_rd_vld), .csr_address(csr_address),
    .csr_rd_ack(csr_rd_ack), .csr_rd_data(csr_rd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] aeg_of(input int unsigned i);
    return aeg_flat[i*64 +: 64];
  endfunction

  task automatic aeg_wr(input int unsigned idx, input logic [63:0] data);
    disp_aeg_wr = 1'b1; disp_aeg_idx = 18'(idx); disp_aeg_wr_data = data;
    if (idx < NUM_AEG && idx != 4 && idx != 5 && idx != 7) shadow[idx] = data;
    tick();
    disp_aeg_wr = 1'b0;
  endtask

  task automatic aeg_rd(input int unsigned idx, input logic [63:0] exp);
    disp_aeg_rd = 1'b1; disp_aeg_idx = 18'(idx);
    rtn_q.push_back(exp);
    tick();
    disp_aeg_rd = 1'b0;
  endtask

  task automatic csr_rd(input logic [15:0] addr, input logic [63:0] exp);
    csr_rd_vld = 1'b1; csr_address = addr;
    csr_q.push_back(exp);
    tick();
    csr_rd_vld = 1'b0;
  endtask

  task automatic send_inst(input logic [4:0] inst);
    disp_inst_vld = 1'b1; disp_inst = inst;
    tick();
    disp_inst_vld = 1'b0;
  endtask

  // Scoreboard side: compare returned data against queued expectations.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (disp_rtn_data_vld) begin
        if (rtn_q.size() == 0) chk("rtn_unexpected", 64'd1, 64'd0);
        else chk("rtn_data", disp_rtn_data, rtn_q.pop_front());
      end
      if (csr_rd_ack) begin
        if (csr_q.size() == 0) chk("csr_unexpected", 64'd1, 64'd0);
        else chk("csr_data", csr_rd_data, csr_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; disp_inst_vld = 1'b0; disp_inst = '0; disp_aeg_idx = '0;
    disp_aeg_rd = 1'b0; disp_aeg_wr = 1'b0; disp_aeg_wr_data = '0;
    is_master = 1'b1; core_done = 1'b0; core_gvt = '0;
    csr_rd_vld = 1'b0; csr_address = '0;
    for (int i = 0; i < NUM_AEG; i++) shadow[i] = '0;

    // Reset state
    #12;
    chk("rst_idle", 64'(disp_idle), 64'd1);
    chk("rst_stall", 64'(disp_stall), 64'd0);
    chk("rst_cnt", 64'(disp_aeg_cnt), 64'd8);
    chk("rst_exc", 64'(disp_exception), 64'd0);
    chk("rst_core_rst_n", 64'(core_rst_n), 64'd0);
    chk("rst_aeg_or", 64'(|aeg_flat), 64'd0);
    @(posedge clk); #3 rst_n = 1'b1;
    tick();

    // Master run ending on core_done
    aeg_wr(1, 64'd100);
    aeg_rd(1, shadow[1]);
    disp_inst_vld = 1'b1; disp_inst = 5'd0; #1;
    chk("start_stall", 64'(disp_stall), 64'd1);
    chk("start_idle", 64'(disp_idle), 64'd0);
    tick(); disp_inst_vld = 1'b0;
    chk("run_core_rst_n", 64'(core_rst_n), 64'd1);
    repeat (50) tick();
    core_done = 1'b1; core_gvt = 16'h0064;
    tick(); core_done = 1'b0;
    chk("done_gvt", aeg_of(4), 64'h64);
    chk("done_status", aeg_of(7), 64'h5);
    chk("done_count", aeg_of(5), 64'd51);
    chk("done_core_rst_n", 64'(core_rst_n), 64'd0);
    tick();
    chk("done_idle", 64'(disp_idle), 64'd1);
    chk("done_stall", 64'(disp_stall), 64'd0);
    csr_rd(16'd1, 64'h64);
    csr_rd(16'd2, 64'd51);
    csr_rd(16'd0, 64'h4);
    csr_rd(16'd9, 64'd0);

    // Bad index plus unimplemented instruction in one cycle
    disp_aeg_rd = 1'b1; disp_aeg_idx = 18'd8; disp_inst_vld = 1'b1; disp_inst = 5'd5;
    rtn_q.push_back(64'd0);
    tick();
    disp_aeg_rd = 1'b0; disp_inst_vld = 1'b0;
    chk("bad_exc", 64'(disp_exception), 64'h3);
    tick();
    chk("bad_exc_clear", 64'(disp_exception), 64'h0);
    aeg_wr(4, 64'hdead);
    aeg_rd(4, 64'h64);
    aeg_wr(9, 64'h1);
    chk("bad_wr_exc", 64'(disp_exception), 64'h2);

    // Timeout after AEG6 cycles
    aeg_wr(6, 64'd10);
    send_inst(5'd0);
    repeat (9) tick();
    chk("to_pre_count", aeg_of(5), 64'd9);
    chk("to_pre_core", 64'(core_rst_n), 64'd1);
    tick();
    chk("to_exc", 64'(disp_exception), 64'h4);
    chk("to_count", aeg_of(5), 64'd10);
    chk("to_status", aeg_of(7), 64'h9);
    chk("to_core_rst_n", 64'(core_rst_n), 64'd0);
    chk("to_gvt_kept", aeg_of(4), 64'h64);
    tick();
    chk("to_exc_clear", 64'(disp_exception), 64'h0);
    chk("to_idle", 64'(disp_idle), 64'd1);
    aeg_wr(6, 64'd0);

    // Abort racing core_done: done wins
    send_inst(5'd0);
    repeat (3) tick();
    disp_inst_vld = 1'b1; disp_inst = 5'd1; core_done = 1'b1; core_gvt = 16'h1234;
    tick();
    disp_inst_vld = 1'b0; core_done = 1'b0;
    chk("race_gvt", aeg_of(4), 64'h1234);
    chk("race_status", aeg_of(7), 64'h5);
    tick();

    // Plain abort; inst 1 in IDLE ignored
    send_inst(5'd1);
    chk("abort_idle_ign", 64'(disp_idle), 64'd1);
    send_inst(5'd0);
    tick();
    send_inst(5'd1);
    chk("abort_status", aeg_of(7), 64'hD);
    chk("abort_core_rst_n", 64'(core_rst_n), 64'd0);
    chk("abort_gvt_kept", aeg_of(4), 64'h1234);
    tick();

    // Non-master sequence
    is_master = 1'b0;
    send_inst(5'd0);
    chk("nm_run_core", 64'(core_rst_n), 64'd0);
    chk("nm_run_stall", 64'(disp_stall), 64'd1);
    tick();
    chk("nm_done_status", aeg_of(7), 64'h5);
    chk("nm_done_stall", 64'(disp_stall), 64'd1);
    chk("nm_done_core", 64'(core_rst_n), 64'd0);
    tick();
    chk("nm_idle", 64'(disp_idle), 64'd1);
    is_master = 1'b1;

    // Reset in the middle of a run
    aeg_wr(2, 64'h55);
    aeg_rd(2, shadow[2]);
    send_inst(5'd0);
    repeat (20) tick();
    chk("mid_core_on", 64'(core_rst_n), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_stall", 64'(disp_stall), 64'd0);
    chk("mid_core_off", 64'(core_rst_n), 64'd0);
    chk("mid_aeg_or", 64'(|aeg_flat), 64'd0);
    chk("mid_idle", 64'(disp_idle), 64'd1);
    for (int i = 0; i < NUM_AEG; i++) shadow[i] = '0;
    @(posedge clk); #3 rst_n = 1'b1;
    tick();
    aeg_rd(2, shadow[2]);
    csr_rd(16'd2, 64'd0);
    repeat (3) tick();

    chk("rtn_q_empty", 64'(rtn_q.size()), 64'd0);
    chk("csr_q_empty", 64'(csr_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
